// File: rtl/div_exerciser_pkg.sv
// rtl/div_exerciser_pkg.sv - shared width, latency and operand types for the divider self-test
package div_exerciser_pkg;

    localparam int W       = 16;
    localparam int LATENCY = W;

    typedef logic [W-1:0] operand_t;

    localparam operand_t DIV0_QUOT = '1;

endpackage

// File: rtl/div_pipe.sv
// rtl/div_pipe.sv - W-stage pipelined unsigned restoring divider with valid and operand sideband
module div_pipe
    import div_exerciser_pkg::*;
(
    input  logic     CLK,
    input  logic     RESET,
    input  logic     in_valid,
    input  operand_t numer,
    input  operand_t denom,
    output logic     out_valid,
    output operand_t quotient,
    output operand_t remain,
    output operand_t out_numer,
    output operand_t out_denom
);

    logic     valid_q [LATENCY];
    operand_t rem_q   [LATENCY];
    operand_t dvd_q   [LATENCY];
    operand_t den_q   [LATENCY];
    operand_t num_q   [LATENCY];
    operand_t rem_d   [LATENCY];
    operand_t dvd_d   [LATENCY];

    // dvd shifts dividend bits out at the top while quotient bits shift in at the bottom,
    // so after the last stage it holds the full quotient. A zero divisor always subtracts,
    // giving all-ones quotient and remainder equal to the numerator without special casing.
    for (genvar s = 0; s < LATENCY; s++) begin : g_stage
        operand_t   rem_in;
        operand_t   dvd_in;
        operand_t   den_in;
        logic [W:0] trial;
        logic       ge;

        if (s == 0) begin : g_head
            assign rem_in = '0;
            assign dvd_in = numer;
            assign den_in = denom;
        end else begin : g_body
            assign rem_in = rem_q[s-1];
            assign dvd_in = dvd_q[s-1];
            assign den_in = den_q[s-1];
        end

        assign trial    = {rem_in, dvd_in[W-1]};
        assign ge       = trial >= {1'b0, den_in};
        assign rem_d[s] = ge ? operand_t'(trial - {1'b0, den_in}) : trial[W-1:0];
        assign dvd_d[s] = {dvd_in[W-2:0], ge};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int s = 0; s < LATENCY; s++) valid_q[s] <= 1'b0;
        end else begin
            valid_q[0] <= in_valid;
            for (int s = 1; s < LATENCY; s++) valid_q[s] <= valid_q[s-1];
        end
    end

    always_ff @(posedge CLK) begin
        den_q[0] <= denom;
        num_q[0] <= numer;
        for (int s = 1; s < LATENCY; s++) begin
            den_q[s] <= den_q[s-1];
            num_q[s] <= num_q[s-1];
        end
        for (int s = 0; s < LATENCY; s++) begin
            rem_q[s] <= rem_d[s];
            dvd_q[s] <= dvd_d[s];
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign quotient  = dvd_q[LATENCY-1];
    assign remain    = rem_q[LATENCY-1];
    assign out_numer = num_q[LATENCY-1];
    assign out_denom = den_q[LATENCY-1];

endmodule

// File: rtl/div_exerciser.sv
// rtl/div_exerciser.sv - divider built-in self-test: operand stream, pipelined divide, result checker
module div_exerciser
    import div_exerciser_pkg::*;
#(
    parameter operand_t NUMER_INIT = 16'd100,
    parameter operand_t NUMER_STEP = 16'd1,
    parameter operand_t DENOM_INIT = 16'd7
) (
    input  logic     CLK,
    input  logic     RESET,
    input  logic     en,
    output operand_t numer,
    output operand_t denom,
    output operand_t quotient,
    output operand_t remain,
    output logic     res_valid,
    output logic     err,
    output operand_t err_cnt,
    output operand_t res_cnt
);

    logic           p_valid;
    operand_t       p_quot;
    operand_t       p_rem;
    operand_t       p_numer;
    operand_t       p_denom;
    operand_t       chk_numer;
    operand_t       chk_denom;
    logic [2*W-1:0] prod;
    logic           pass;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            numer <= NUMER_INIT;
            denom <= DENOM_INIT;
        end else if (en) begin
            numer <= numer + NUMER_STEP;
            denom <= denom + 1'b1;
        end
    end

    div_pipe u_pipe (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (en),
        .numer     (numer),
        .denom     (denom),
        .out_valid (p_valid),
        .quotient  (p_quot),
        .remain    (p_rem),
        .out_numer (p_numer),
        .out_denom (p_denom)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            res_valid <= 1'b0;
            quotient  <= '0;
            remain    <= '0;
            chk_numer <= '0;
            chk_denom <= '0;
        end else begin
            res_valid <= p_valid;
            if (p_valid) begin
                quotient  <= p_quot;
                remain    <= p_rem;
                chk_numer <= p_numer;
                chk_denom <= p_denom;
            end
        end
    end

    // Reconstruct the numerator in double width so a wrong quotient cannot alias via overflow.
    always_comb begin
        prod = (2*W)'(quotient) * (2*W)'(chk_denom) + (2*W)'(remain);
        pass = 1'b0;
        if (chk_denom == '0)
            pass = (quotient == DIV0_QUOT) && (remain == chk_numer);
        else
            pass = (prod == (2*W)'(chk_numer)) && (remain < chk_denom);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            err     <= 1'b0;
            err_cnt <= '0;
            res_cnt <= '0;
        end else if (res_valid) begin
            if (res_cnt != '1) res_cnt <= res_cnt + 1'b1;
            if (!pass) begin
                err <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_exerciser.sv
// tb/tb_div_exerciser.sv - directed vector bench for div_exerciser
module tb_div_exerciser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;

    logic [15:0] numer0, denom0, quot0, rem0, errc0, resc0;
    logic [15:0] numer1, denom1, quot1, rem1, errc1, resc1;
    logic [15:0] numer2, denom2, quot2, rem2, errc2, resc2;
    logic        rv0, err0, rv1, err1, rv2, err2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] q0, r0, q1, r1, q2, r2;
    } vec_t;

    vec_t tbl [4];
    logic hist [64];

    always #5 clk = ~clk;

    div_exerciser u0 (
        .CLK(clk), .RESET(rst_n), .en(en), .numer(numer0), .denom(denom0),
        .quotient(quot0), .remain(rem0), .res_valid(rv0), .err(err0),
        .err_cnt(errc0), .res_cnt(resc0)
    );

    div_exerciser #(.NUMER_INIT(16'h1234), .NUMER_STEP(16'd1), .DENOM_INIT(16'd0)) u1 (
        .CLK(clk), .RESET(rst_n), .en(en), .numer(numer1), .denom(denom1),
        .quotient(quot1), .remain(rem1), .res_valid(rv1), .err(err1),
        .err_cnt(errc1), .res_cnt(resc1)
    );

    div_exerciser #(.NUMER_INIT(16'hFFFF), .NUMER_STEP(16'd1), .DENOM_INIT(16'd1)) u2 (
        .CLK(clk), .RESET(rst_n), .en(en), .numer(numer2), .denom(denom2),
        .quotient(quot2), .remain(rem2), .res_valid(rv2), .err(err2),
        .err_cnt(errc2), .res_cnt(resc2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        rst_n = 1'b0;
        en = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int stale;

        tbl[0] = '{16'd14, 16'd2,  16'hFFFF, 16'h1234, 16'hFFFF, 16'd0};
        tbl[1] = '{16'd12, 16'd5,  16'h1235, 16'd0,    16'd0,    16'd0};
        tbl[2] = '{16'd11, 16'd3,  16'h091B, 16'd0,    16'd0,    16'd1};
        tbl[3] = '{16'd10, 16'd3,  16'h0612, 16'd1,    16'd0,    16'd2};

        // reset state
        tick();
        tick();
        check("rst numer0", numer0, 16'd100);
        check("rst denom0", denom0, 16'd7);
        check("rst quot0", quot0, 16'd0);
        check("rst rem0", rem0, 16'd0);
        check("rst rv0", rv0, 1'b0);
        check("rst err0", err0, 1'b0);
        check("rst resc0", resc0, 16'd0);
        check("rst errc0", errc0, 16'd0);
        check("rst numer1", numer1, 16'h1234);
        check("rst denom1", denom1, 16'd0);

        // continuous issue from edge 1
        rst_n = 1'b1;
        en = 1'b1;
        for (int k = 1; k <= 16; k++) tick();
        check("latency rv0 at 16", rv0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("vec%0d rv0", i), rv0, 1'b1);
            check($sformatf("vec%0d q0", i), quot0, tbl[i].q0);
            check($sformatf("vec%0d r0", i), rem0, tbl[i].r0);
            check($sformatf("vec%0d q1", i), quot1, tbl[i].q1);
            check($sformatf("vec%0d r1", i), rem1, tbl[i].r1);
            check($sformatf("vec%0d q2", i), quot2, tbl[i].q2);
            check($sformatf("vec%0d r2", i), rem2, tbl[i].r2);
            if (i == 0) begin
                check("numer0 at 17", numer0, 16'd117);
                check("denom0 at 17", denom0, 16'd24);
            end
        end
        check("resc0 at 20", resc0, 16'd3);
        check("err0 early", err0, 1'b0);
        check("err1 early", err1, 1'b0);
        check("err2 early", err2, 1'b0);

        // long run through the full denom wrap until res_cnt saturates
        for (int k = 21; k <= 65560; k++) begin
            tick();
            if (k == 65551) check("resc0 before sat", resc0, 16'hFFFE);
            if (k == 65552) check("resc0 sat", resc0, 16'hFFFF);
        end
        check("resc0 held sat", resc0, 16'hFFFF);
        check("resc1 held sat", resc1, 16'hFFFF);
        check("long err0", err0, 1'b0);
        check("long errc0", errc0, 16'd0);
        check("long err1", err1, 1'b0);
        check("long errc1", errc1, 16'd0);
        check("long err2", err2, 1'b0);
        check("long errc2", errc2, 16'd0);

        // reset with 8 operations in flight
        restart();
        en = 1'b1;
        for (int k = 1; k <= 8; k++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst rv0", rv0, 1'b0);
        check("midrst numer0", numer0, 16'd100);
        check("midrst denom0", denom0, 16'd7);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            if (rv0 !== 1'b0) stale++;
        end
        check("stale results", stale, 0);
        check("midrst resc0", resc0, 16'd0);
        en = 1'b1;
        for (int k = 1; k <= 16; k++) tick();
        check("midrst rv0 at 16", rv0, 1'b0);
        tick();
        check("midrst rv0 at 17", rv0, 1'b1);
        check("midrst q0", quot0, 16'd14);
        check("midrst r0", rem0, 16'd2);

        // alternating issue
        restart();
        for (int k = 1; k <= 40; k++) begin
            en = k[0];
            hist[k] = k[0];
            tick();
            check($sformatf("toggle rv0 tick%0d", k), rv0, (k > 16) ? hist[k-16] : 1'b0);
            if (k == 19) begin
                check("toggle q0", quot0, 16'd12);
                check("toggle r0", rem0, 16'd5);
            end
        end
        check("toggle numer0", numer0, 16'd120);
        check("toggle denom0", denom0, 16'd27);
        check("toggle resc0", resc0, 16'd12);
        check("toggle err0", err0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
